i2s_dac_tx: RTL
===============

Name: i2s_dac_tx

Overview:
- Transmit-side companion to the codec ADC capture path: serializes stereo samples onto AUD_DACDAT in I2S format.
- The codec is bus master. AUD_BCLK and AUD_DACLRCK are inputs, sampled in the clk domain.
- Samples enter through a valid/ready FIFO, fed by the processing logic that currently loops adc_left/adc_right back.
- Flags FIFO underruns so software or the display can see dropped frames.

Parameters:
- DATA_WIDTH, 24: bits per channel sample, MSB first.
- FIFO_DEPTH, 4: stereo frames buffered; power of two, minimum 2.
- SYNC_STAGES, 2: synchronizer flops on AUD_BCLK and AUD_DACLRCK; minimum 2.

Ports:
- clk  in  1  system clock, 50 MHz; must be at least 8x the AUD_BCLK frequency.
- reset_n  in  1  asynchronous, active-low reset.
- left_in  in  DATA_WIDTH  left sample, two's complement.
- right_in  in  DATA_WIDTH  right sample, two's complement.
- in_valid  in  1  frame offered.
- in_ready  out  1  FIFO not full.
- AUD_BCLK  in  1  codec bit clock, asynchronous to clk.
- AUD_DACLRCK  in  1  codec word clock; 0 = left, 1 = right.
- AUD_DACDAT  out  1  serial data to the codec.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  frames currently stored.
- underrun  out  1  sticky underrun flag.
- clear_underrun  in  1  synchronous clear of underrun.

Behaviour:
- Reset (async, reset_n=0):
  - FIFO emptied; fifo_level=0; in_ready=0 while reset_n=0, 1 from the first clk edge after release.
  - AUD_DACDAT=0, underrun=0, shift register, holding registers and bit counter cleared.
  - State = WAIT_SYNC.
  - Reset mid-word abandons the word; no partial continuation.
- Clock sync:
  - AUD_BCLK and AUD_DACLRCK each pass through SYNC_STAGES flops.
  - bclk_fall = a one-clk pulse when the synchronized BCLK goes 1->0.
  - At every bclk_fall, sample synchronized LRCK into lrck_q.
  - boundary = bclk_fall AND synchronized LRCK != lrck_q.
- State machine:
  - WAIT_SYNC: AUD_DACDAT held 0. Go to RUN on the first left boundary (LRCK 1->0). Right boundaries are ignored here, so output always starts on a left word.
  - RUN, at each boundary:
    - Left boundary: pop one FIFO frame into hold_l/hold_r, then load the shift register from hold_l.
    - Right boundary: load the shift register from hold_r.
    - In both cases set bit_cnt=0 and drive AUD_DACDAT=0 for this bit period (I2S one-BCLK delay).
  - RUN, at each non-boundary bclk_fall:
    - If bit_cnt < DATA_WIDTH: AUD_DACDAT = shift MSB; shift left by one; bit_cnt++.
    - Otherwise AUD_DACDAT=0 (pad bits).
- Slot length:
  - A half-frame longer than DATA_WIDTH+1 BCLKs is zero-padded.
  - A shorter half-frame truncates LSBs at the next boundary; no error is flagged.
- Output timing: AUD_DACDAT changes SYNC_STAGES+1 clk cycles after the physical BCLK fall and is held stable until the next fall.
- Underrun:
  - Condition: the FIFO is empty at a left boundary.
  - Action: hold_l=hold_r=0 (see Optional Feature), underrun <= 1.
  - Data flow continues; the machine stays in RUN.
- underrun clear:
  - Cleared only by clear_underrun=1.
  - If a set and a clear happen in the same cycle, the set wins.
- FIFO:
  - Push when in_valid && in_ready.
  - in_ready = !full, taken from registered state. When full, a push is refused even if a pop occurs in the same cycle.
  - A push into an empty FIFO in the same cycle as a pop is not bypassed: the pop sees empty and an underrun is recorded; the pushed frame stays stored.
  - Push and pop in the same cycle with 0 < level < DEPTH: level unchanged.
  - Read and write pointers wrap modulo FIFO_DEPTH.
  - fifo_level is registered and exact.
- Data widths: samples are passed bit-exact, with no sign-extension or rounding.

Optional Feature:
- Macro: I2S_UNDERRUN_HOLD_EN.
- Defined: on underrun, hold_l/hold_r keep the last transmitted frame, so the previous sample repeats. underrun is still set.
- Undefined: on underrun, hold_l/hold_r = 0 and silence is transmitted.

Test Plan:
- Left-word serialization:
  - Stimulus: reset, then push L=24'hA5F00F, R=24'h123456. Drive BCLK at 3.072 MHz with 32 BCLKs per half-frame, LRCK starting at 1.
  - Response: nothing is sent before the first LRCK fall. After it, AUD_DACDAT is 0 for one bit, then A5F00F MSB-first, then 7 zeros.
- Right-word serialization: same stimulus as above; after the LRCK rise, DACDAT is 0, then 123456 MSB-first. fifo_level is 0 after the pop.
- Underrun, default build:
  - Stimulus: no frames pushed for two frames.
  - Response: DACDAT is all zero and underrun=1. A clear_underrun pulse gives underrun=0.
  - With set and clear in the same cycle, underrun stays 1.
- FIFO full and wrap-around:
  - Stimulus: hold in_valid=1 with 6 distinct frames, DEPTH=4, BCLK stopped.
  - Response: 4 frames accepted, in_ready=0, fifo_level=4.
  - Restart BCLK: the frames are output in order; the pointers wrap and later pushes are accepted.
- Reset mid-word:
  - Stimulus: assert reset_n=0 on bit 10 of a left word.
  - Response: DACDAT=0 immediately; the FIFO is empty.
  - After release, no output until the next LRCK fall; the previously held data does not reappear.
- Hold build (I2S_UNDERRUN_HOLD_EN defined):
  - Stimulus: send frame L=24'h000001, then an empty FIFO.
  - Response: 24'h000001 repeats on the left channel and underrun=1.

Source files
------------

// File: rtl/i2s_dac_tx.sv
// I2S transmitter: stereo frame FIFO, codec-mastered BCLK/LRCK sync, MSB-first serializer.
// Build option I2S_UNDERRUN_HOLD_EN: on underrun repeat the last frame instead of sending silence.
module i2s_dac_tx #(
  parameter int DATA_WIDTH  = 24,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [DATA_WIDTH-1:0]         left_in,
  input  logic [DATA_WIDTH-1:0]         right_in,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          AUD_BCLK,
  input  logic                          AUD_DACLRCK,
  output logic                          AUD_DACDAT,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          underrun,
  input  logic                          clear_underrun
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(DATA_WIDTH + 1);

  typedef enum logic {WAIT_SYNC, RUN} state_t;

  logic [SYNC_STAGES-1:0] bclk_sync, lrck_sync;
  logic                   bclk_s, lrck_s, bclk_prev, lrck_q;
  logic                   bclk_fall, boundary, left_bnd, right_bnd;

  logic [DATA_WIDTH-1:0]  mem_l [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]  mem_r [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic [LW-1:0]          level, level_nxt;
  logic                   ready_q, push, pop;

  state_t                 state, state_nxt;
  logic [DATA_WIDTH-1:0]  shift, shift_nxt, hold_l, hold_l_nxt, hold_r, hold_r_nxt;
  logic [CW-1:0]          bit_cnt, bit_cnt_nxt;
  logic                   dat, dat_nxt, left_go, under_set;

  assign bclk_s    = bclk_sync[SYNC_STAGES-1];
  assign lrck_s    = lrck_sync[SYNC_STAGES-1];
  assign bclk_fall = bclk_prev & ~bclk_s;
  assign boundary  = bclk_fall & (lrck_s != lrck_q);
  assign left_bnd  = boundary & ~lrck_s;
  assign right_bnd = boundary & lrck_s;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bclk_sync <= '0;
      lrck_sync <= '0;
      bclk_prev <= 1'b0;
      lrck_q    <= 1'b0;
    end else begin
      bclk_sync <= {bclk_sync[SYNC_STAGES-2:0], AUD_BCLK};
      lrck_sync <= {lrck_sync[SYNC_STAGES-2:0], AUD_DACLRCK};
      bclk_prev <= bclk_s;
      if (bclk_fall) lrck_q <= lrck_s;
    end
  end

  // FIFO: ready is registered, so a full FIFO refuses a push even when it pops that cycle
  assign push = in_valid & ready_q;

  always_comb begin
    level_nxt = level;
    case ({push, pop})
      2'b10:   level_nxt = level + LW'(1);
      2'b01:   level_nxt = level - LW'(1);
      default: level_nxt = level;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_l[wr_ptr] <= left_in;
      mem_r[wr_ptr] <= right_in;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      ready_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      level   <= level_nxt;
      ready_q <= (level_nxt != LW'(FIFO_DEPTH));
    end
  end

  // Next-state and datapath; WAIT_SYNC treats its exit boundary as a normal left boundary
  always_comb begin
    state_nxt   = state;
    shift_nxt   = shift;
    hold_l_nxt  = hold_l;
    hold_r_nxt  = hold_r;
    bit_cnt_nxt = bit_cnt;
    dat_nxt     = dat;
    left_go     = 1'b0;
    under_set   = 1'b0;
    pop         = 1'b0;
    case (state)
      WAIT_SYNC: begin
        dat_nxt = 1'b0;
        if (left_bnd) begin
          state_nxt = RUN;
          left_go   = 1'b1;
        end
      end
      RUN: begin
        if (left_bnd) begin
          left_go = 1'b1;
        end else if (right_bnd) begin
          shift_nxt   = hold_r;
          bit_cnt_nxt = '0;
          dat_nxt     = 1'b0;
        end else if (bclk_fall) begin
          if (bit_cnt < CW'(DATA_WIDTH)) begin
            dat_nxt     = shift[DATA_WIDTH-1];
            shift_nxt   = {shift[DATA_WIDTH-2:0], 1'b0};
            bit_cnt_nxt = bit_cnt + CW'(1);
          end else begin
            dat_nxt = 1'b0;
          end
        end
      end
      default: state_nxt = WAIT_SYNC;
    endcase
    if (left_go) begin
      if (level != '0) begin
        pop        = 1'b1;
        hold_l_nxt = mem_l[rd_ptr];
        hold_r_nxt = mem_r[rd_ptr];
      end else begin
        under_set  = 1'b1;
`ifdef I2S_UNDERRUN_HOLD_EN
        hold_l_nxt = hold_l;
        hold_r_nxt = hold_r;
`else
        hold_l_nxt = '0;
        hold_r_nxt = '0;
`endif
      end
      shift_nxt   = hold_l_nxt;
      bit_cnt_nxt = '0;
      dat_nxt     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= WAIT_SYNC;
      shift    <= '0;
      hold_l   <= '0;
      hold_r   <= '0;
      bit_cnt  <= '0;
      dat      <= 1'b0;
      underrun <= 1'b0;
    end else begin
      state   <= state_nxt;
      shift   <= shift_nxt;
      hold_l  <= hold_l_nxt;
      hold_r  <= hold_r_nxt;
      bit_cnt <= bit_cnt_nxt;
      dat     <= dat_nxt;
      if (under_set)           underrun <= 1'b1;
      else if (clear_underrun) underrun <= 1'b0;
    end
  end

  assign AUD_DACDAT = dat;
  assign in_ready   = ready_q;
  assign fifo_level = level;

endmodule
